// File: rtl/pc_stack.sv
// pc_stack: program counter with a small shift-register return/data stack.
// Each cycle one op (INC, BRANCH, CALL, RET, PUSH, POP) is applied on the
// rising clock edge unless stall is high. The stack has no pointer; push
// shifts every level down and pop shifts every level up, with the bottom
// level duplicating itself.
//
// Optional feature: define PC_STACK_DEPTH_FLAGS_EN to compile in the
// occupancy counter (depth) and the sticky stack_ovf / stack_unf flags.
// Without it those outputs are tied to zero and no counter logic exists.
module pc_stack #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     pc_op,
  input  logic                           cond,
  input  logic [ADDR_WIDTH-1:0]          target,
  input  logic [ADDR_WIDTH-1:0]          push_data,
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic [ADDR_WIDTH-1:0]          stack_top,
  output logic [$clog2(DEPTH+1)-1:0]     depth,
  output logic                           stack_ovf,
  output logic                           stack_unf
);

  localparam int DW = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_CALL   = 3'b010;
  localparam logic [2:0] OP_RET    = 3'b011;
  localparam logic [2:0] OP_PUSH   = 3'b100;
  localparam logic [2:0] OP_POP    = 3'b101;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] stk_q [DEPTH];
  logic [ADDR_WIDTH-1:0] stk_d [DEPTH];
  logic [ADDR_WIDTH-1:0] push_val;
  logic                  do_push;
  logic                  do_pop;

  // Sequential successor address; wraps naturally at all-ones.
  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  // Op decode: next pc and stack request. Stall masks everything so that
  // no state (pc, stack, counter, flags) can move while it is high.
  always_comb begin
    pc_d     = pc_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    push_val = pc_inc;
    if (!stall) begin
      case (pc_op)
        OP_INC:    pc_d = pc_inc;
        OP_BRANCH: pc_d = cond ? target : pc_inc;
        OP_CALL: begin
          pc_d     = target;
          do_push  = 1'b1;
          push_val = pc_inc;
        end
        OP_RET: begin
          // Return address is the pre-edge top of stack.
          pc_d   = stk_q[0];
          do_pop = 1'b1;
        end
        OP_PUSH: begin
          pc_d     = pc_inc;
          do_push  = 1'b1;
          push_val = push_data;
        end
        OP_POP: begin
          pc_d   = pc_inc;
          do_pop = 1'b1;
        end
        // Reserved codes are plain increments.
        default:   pc_d = pc_inc;
      endcase
    end
  end

  // Stack next state: shift down on push, shift up on pop, bottom repeats.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stk_d[i] = stk_q[i];
    end
    if (do_push) begin
      stk_d[0] = push_val;
      for (int i = 1; i < DEPTH; i++) begin
        stk_d[i] = stk_q[i-1];
      end
    end else if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        stk_d[i] = stk_q[i+1];
      end
    end
  end

  // pc and stack registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      pc_q <= pc_d;
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= stk_d[i];
      end
    end
  end

  // Both outputs come straight from registers: no input-to-output path.
  assign pc        = pc_q;
  assign stack_top = stk_q[0];

`ifdef PC_STACK_DEPTH_FLAGS_EN
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  // Saturating occupancy count; overflow/underflow attempts latch a flag.
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (do_push) begin
      if (depth_q == DEPTH_MAX) begin
        ovf_d = 1'b1;
      end else begin
        depth_d = depth_q + DW'(1);
      end
    end else if (do_pop) begin
      if (depth_q == '0) begin
        unf_d = 1'b1;
      end else begin
        depth_d = depth_q - DW'(1);
      end
    end
  end

  // Counter and sticky flags; only reset clears the flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign depth     = depth_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  assign depth     = '0;
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, program-address width and width of each stack entry.
REQ-002 Parameter DEPTH, default 4, number of hardware stack levels (minimum 2).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port stall  input  1  1 = freeze all state this cycle.
REQ-006 Port pc_op  input  3  000 INC, 001 BRANCH, 010 CALL, 011 RET, 100 PUSH, 101 POP, 110/111 reserved.
REQ-007 Port cond  input  1  branch condition from the ALU/accumulator status; used by BRANCH only.
REQ-008 Port target  input  ADDR_WIDTH  branch/call destination from the instruction word.
REQ-009 Port push_data  input  ADDR_WIDTH  low ADDR_WIDTH bits of the accumulator, for PUSH.
REQ-010 Port pc  output  ADDR_WIDTH  current fetch address; drives the instruction memory address.
REQ-011 Port stack_top  output  ADDR_WIDTH  stack level 0, combinational from the register; feeds the accumulator input mux stack leg.
REQ-012 Port depth  output  clog2(DEPTH+1)  occupied levels (macro-dependent; see Configuration).
REQ-013 Port stack_ovf  output  1  sticky push-when-full flag (macro-dependent).
REQ-014 Port stack_unf  output  1  sticky pop-when-empty flag (macro-dependent).

Function
REQ-015 Stack: DEPTH registers s[0] (top) .. s[DEPTH-1] (bottom), shift-register organisation, no pointer.
REQ-016 Push: s[i] <= s[i-1] for i>=1, s[0] <= value; the old s[DEPTH-1] is discarded.
REQ-017 Pop: s[i] <= s[i+1] for i<DEPTH-1; s[DEPTH-1] keeps its value (bottom level duplicates).
REQ-018 INC: pc <= pc+1, modulo 2^ADDR_WIDTH (all-ones wraps to 0); stack unchanged.
REQ-019 BRANCH: if cond=1, pc <= target; if cond=0, behaves as INC.
REQ-020 CALL: push (pc+1) mod 2^ADDR_WIDTH; pc <= target; single cycle.
REQ-021 RET: pc <= s[0] (pre-edge value), then pop.
REQ-022 PUSH: push push_data; pc <= pc+1.
REQ-023 POP: pop; pc <= pc+1; the consumer captures stack_top on the same edge, so no extra latency.
REQ-024 Reserved codes 110/111 behave exactly as INC.
REQ-025 stall=1 overrides pc_op: pc, every s[i], depth and flags hold; outputs stay stable.
REQ-026 All state changes take effect one clock after the op is presented; pc and stack_top carry no combinational path from any input.

Reset
REQ-027 reset low asynchronously forces pc=0, all s[i]=0, depth=0, stack_ovf=0, stack_unf=0, with effect independent of clk.
REQ-028 Reset asserted mid-operation (including during a CALL or RET edge) wins; the first op is sampled on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro PC_STACK_DEPTH_FLAGS_EN, when defined, compiles in the depth counter and both sticky flags.
REQ-030 With the macro: push ops (CALL, PUSH) increment depth, saturating at DEPTH; a push at depth=DEPTH sets stack_ovf.
REQ-031 With the macro: pop ops (RET, POP) decrement depth, saturating at 0; a pop at depth=0 sets stack_unf.
REQ-032 With the macro: flags clear only on reset; stall holds them.
REQ-033 Without the macro: depth, stack_ovf and stack_unf are constant 0 and no counter logic exists; stack data behaviour is identical either way.

Verification
REQ-034 Reset, then 4100 INC cycles -> pc counts 0..4095, wraps to 0, reaches 3; stack_top=0 throughout.
REQ-035 At pc=0x010, CALL target=0x200 -> pc=0x200, stack_top=0x011; then RET -> pc=0x011, depth back to 0.
REQ-036 PUSH 0xA01,0xA02,0xA03,0xA04,0xA05 -> s=[A05,A04,A03,A02], stack_ovf=1; then 5 POPs -> stack_top sequence A05,A04,A03,A02,A02, stack_unf=1 after the 5th.
REQ-037 BRANCH target=0x3FF with cond=0 at pc=0x020 -> pc=0x021; with cond=1 -> pc=0x3FF.
REQ-038 CALL with stall=1 held for 3 cycles -> pc, stack and flags unchanged; on release, the CALL executes once.
REQ-039 reset pulsed low between edges while stack is full and pc=0x155 -> pc, all s[i], depth and flags read 0 immediately, before the next clk edge.
